// File: rtl/stream_demux.sv
// One-input, two-output packet demultiplexer with a one-beat holding slot per channel.
// A packet's destination is taken from in_sel on its first beat and held until in_last.
module stream_demux #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             route_q, route_d;
  logic             target;
  logic             accept;
  logic [1:0]       slot_ready;
  logic [1:0]       slot_valid;
  logic [1:0]       slot_last;
  logic [WIDTH-1:0] slot_data [2];
  logic [1:0]       load;
  logic [1:0]       drain;

  assign slot_ready = {out1_ready, out0_ready};

  // in_sel only matters on the first beat; mid-packet beats follow the locked route.
  assign target   = (state_q == BUSY) ? route_q : in_sel;
  assign in_ready = ~slot_valid[target] | slot_ready[target];
  assign accept   = in_valid & in_ready;
  assign load     = accept ? (2'b01 << target) : 2'b00;
  assign drain    = slot_valid & slot_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d = BUSY;
            route_d = in_sel;
          end
        end
        BUSY: begin
          if (in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // A load wins over a same-edge drain, giving back-to-back beats without a bubble.
  // NOTE: the payload registers are reset too, so outputs read zero during reset rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_last  <= '0;
      for (int k = 0; k < 2; k++) slot_data[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (load[k]) begin
          slot_valid[k] <= 1'b1;
          slot_data[k]  <= in_data;
          slot_last[k]  <= in_last;
        end else if (drain[k]) begin
          slot_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out0_data  = slot_data[0];
  assign out0_last  = slot_last[0];
  assign out0_valid = slot_valid[0];
  assign out1_data  = slot_data[1];
  assign out1_last  = slot_last[1];
  assign out1_valid = slot_valid[1];

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios plus random stress against a
// transaction-level model (packet routing rule + one-entry queue per channel).
module tb_stream_demux;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_sel = 1'b0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out0_data, out1_data;
  logic         out0_last, out1_last;
  logic         out0_valid, out1_valid;
  logic         out0_ready = 1'b0;
  logic         out1_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  // Model: beats accepted into each channel and not yet taken downstream.
  beat_t q0[$];
  beat_t q1[$];
  bit    in_pkt = 0;
  bit    lock_sel = 0;
  int    n_acc = 0;

  stream_demux #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_last(out0_last),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_last(out1_last),
    .out1_valid(out1_valid), .out1_ready(out1_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out0_valid", out0_valid, q0.size() != 0);
    if (q0.size() != 0) begin
      check("out0_data", out0_data, q0[0].data);
      check("out0_last", out0_last, q0[0].last);
    end
    check("out1_valid", out1_valid, q1.size() != 0);
    if (q1.size() != 0) begin
      check("out1_data", out1_data, q1[0].data);
      check("out1_last", out1_last, q1[0].last);
    end
  endtask

  // One clock: drive at negedge, check against the model, then advance the model past the posedge.
  task automatic cycle(input logic v, input logic sel, input logic last,
                       input logic [W-1:0] d, input logic r0, input logic r1);
    bit t, er, acc;
    beat_t b;
    @(negedge clk);
    in_valid = v; in_sel = sel; in_last = last; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    check_outputs();
    t  = in_pkt ? lock_sel : sel;
    er = t ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    check("in_ready", in_ready, er);
    acc = v && er;
    @(posedge clk);
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (acc) begin
      b.data = d; b.last = last;
      if (t) q1.push_back(b); else q0.push_back(b);
      n_acc++;
      if (last) in_pkt = 0;
      else if (!in_pkt) begin in_pkt = 1; lock_sel = sel; end
    end
  endtask

  // Asserts reset away from a clock edge with a valid beat offered; nothing may transfer.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_last = 1'b1; in_data = 32'hDEAD_BEEF;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #1;
    check("rst out0_valid", out0_valid, 1'b0);
    check("rst out1_valid", out1_valid, 1'b0);
    check("rst out0_data", out0_data, '0);
    check("rst out1_last", out1_last, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    q0.delete(); q1.delete(); in_pkt = 0; lock_sel = 0;
    @(posedge clk);
    #1;
    check("rst no transfer", out1_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    apply_reset();

    // Single beat to out1.
    cycle(1, 1, 1, 32'hA5A5_0001, 1, 1);
    #1;
    check("single out1_valid", out1_valid, 1'b1);
    check("single out1_data", out1_data, 32'hA5A5_0001);
    check("single out1_last", out1_last, 1'b1);
    check("single out0_valid", out0_valid, 1'b0);
    cycle(0, 0, 0, '0, 1, 1);

    // Packet lock: in_sel toggles mid-packet but all beats stay on out0.
    for (int i = 0; i < 3; i++) begin
      cycle(1, (i == 1), (i == 2), 32'h10 + i, 1, 1);
      #1;
      check("lock out0_data", out0_data, 32'h10 + i);
      check("lock out0_last", out0_last, (i == 2));
      check("lock out1_valid", out1_valid, 1'b0);
    end
    cycle(0, 0, 0, '0, 1, 1);

    // Backpressure on out0, then release with a same-edge drain and load.
    cycle(1, 0, 1, 32'h0000_00A0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 32'h0000_00B0, 0, 0);
      check("bp in_ready low", in_ready, 1'b0);
      check("bp held data", out0_data, 32'h0000_00A0);
    end
    cycle(1, 0, 1, 32'h0000_00B0, 1, 0);
    #1;
    check("bp continuous valid", out0_valid, 1'b1);
    check("bp second beat", out0_data, 32'h0000_00B0);

    // Concurrent: out0 drains while a beat loads into out1.
    cycle(1, 1, 1, 32'h0000_00C1, 1, 0);
    #1;
    check("conc out0 drained", out0_valid, 1'b0);
    check("conc out1 loaded", out1_data, 32'h0000_00C1);
    cycle(0, 0, 0, '0, 1, 1);

    // Reset in the middle of a 4-beat packet to out1.
    cycle(1, 1, 0, 32'h0000_0D01, 0, 0);
    cycle(1, 0, 0, 32'h0000_0D02, 1, 0);
    apply_reset();
    cycle(1, 0, 1, 32'h0000_0E01, 0, 0);
    #1;
    check("post-rst out0_valid", out0_valid, 1'b1);
    check("post-rst out0_data", out0_data, 32'h0000_0E01);
    check("post-rst out1_valid", out1_valid, 1'b0);
    cycle(0, 0, 0, '0, 1, 1);

    // Random stress: 10k accepted beats.
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
            $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      cyc++;
    end
    check("stress beats accepted", n_acc >= 10000, 1'b1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, 1);
    check("final queues empty", q0.size() + q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: WIDTH, default 32, data width in bits of input and both outputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_data  input  WIDTH  input beat payload.
REQ-005 in_sel  input  1  destination select (0 -> out0, 1 -> out1); sampled only on the first beat of a packet.
REQ-006 in_last  input  1  marks the final beat of a packet.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block accepts the input beat this cycle.
REQ-009 out0_data / out1_data  output  WIDTH  registered payload per channel.
REQ-010 out0_last / out1_last  output  1  registered last flag per channel.
REQ-011 out0_valid / out1_valid  output  1  channel holds a beat.
REQ-012 out0_ready / out1_ready  input  1  downstream accepts the channel beat.

Function
REQ-013 A transfer on any interface SHALL occur on a rising edge where valid and ready are both 1.
REQ-014 Each output channel SHALL contain one holding slot (data, last, valid registers); outk_valid = slot k full.
REQ-015 Packet FSM SHALL have two states: IDLE (next beat starts a packet) and BUSY (mid-packet); route register (1 bit) holds the locked destination.
REQ-016 Target channel SHALL be in_sel in IDLE and route in BUSY; in_sel SHALL be ignored in BUSY.
REQ-017 IDLE, accepted beat with in_last=0 -> BUSY, route <= in_sel; with in_last=1 -> stay IDLE (single-beat packet).
REQ-018 BUSY, accepted beat with in_last=1 -> IDLE; otherwise stay BUSY; no transition without an accepted beat.
REQ-019 in_ready SHALL equal (target slot empty) OR (target outk_ready = 1); it SHALL NOT depend on in_valid.
REQ-020 Accepted beat SHALL load data/last into the target slot; latency in->out exactly one cycle (accepted at edge N, visible at outputs after edge N).
REQ-021 Same-edge drain and load of one slot (full, outk_ready=1, input accepted) SHALL replace contents with the new beat and keep valid=1; no bubble.
REQ-022 Slot drained with no new load SHALL clear valid; data/last keep their last value.
REQ-023 While outk_valid=1 and outk_ready=0, outk_data/outk_last SHALL remain stable.
REQ-024 Non-target channel SHALL drain independently in the same cycle as input loads into the target; both channels may transfer on one edge.
REQ-025 Beats SHALL be delivered in acceptance order per channel; no beat dropped or duplicated.
REQ-026 A packet to one channel SHALL NOT block the other channel's drain; it does block new input until the packet ends.

Reset
REQ-027 While rst_n=0: state IDLE, route 0, out0_valid=out1_valid=0, outk_data=0, outk_last=0; in_ready reflects empty slots (=1).
REQ-028 Reset asserted mid-packet SHALL discard buffered beats and packet lock; first beat after release starts a new packet.
REQ-029 No transfer SHALL occur on the first rising edge where rst_n is still 0.

Verification
REQ-030 Single beat: in_sel=1, in_last=1, in_data=0xA5A5_0001, out1_ready=1 -> out1_valid=1, out1_data=0xA5A5_0001, out1_last=1 one cycle later; out0_valid stays 0.
REQ-031 Packet lock: 3-beat packet (0x10,0x11,0x12) first beat in_sel=0, in_sel toggled on beats 2-3 -> all three on out0 in order, last=1 only on 0x12; out1 silent.
REQ-032 Backpressure: out0_ready=0, two beats to out0 -> first held stable on out0, in_ready=0 for second; raise out0_ready -> second accepted same edge first drains, continuous valid.
REQ-033 Concurrent: out0 full and draining while a beat loads to out1 on same edge -> both transfers occur, no loss.
REQ-034 Reset mid-packet: assert rst_n=0 after beat 2 of 4 to out1 -> both valids 0 immediately; after release, beat with in_sel=0, in_last=1 appears on out0.
REQ-035 Random stress: random valid/ready/sel/last, 10k beats -> scoreboard per channel matches packet-routed order exactly.
